dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_ctrl_cache_line_store.sv | 66 ++++++
 rtl/dcache_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller: defaults, state
// encoding and address-field width helpers.
package dcache_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 30;
  localparam int unsigned DEF_MEMORY_SIZE   = 16;
  localparam int unsigned DEF_BLOCK_SIZE    = 3;
  localparam int unsigned DEF_INDEX_BITS    = 4;
  localparam int unsigned DEF_MEM_LATENCY   = 3;

  // Wide enough for the largest legal latency (15).
  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    WRITE  = 2'd3
  } state_e;

  function automatic int unsigned tag_width(int unsigned memory_size,
                                            int unsigned block_size,
                                            int unsigned index_bits);
    return memory_size - block_size - index_bits;
  endfunction

  function automatic int unsigned line_width(int unsigned data_width,
                                             int unsigned block_size);
    return data_width << block_size;
  endfunction

endpackage

// File: rtl/dcache_ctrl_cache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational read port,
// full-line fill port, single-word update port and flash invalidate.
module cache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned TAG_WIDTH  = tag_width(DEF_MEMORY_SIZE, DEF_BLOCK_SIZE, DEF_INDEX_BITS)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         inval,
  input  logic [INDEX_BITS-1:0]                        rd_index,
  output logic                                         rd_valid,
  output logic [TAG_WIDTH-1:0]                         rd_tag,
  output logic [line_width(DATA_WIDTH, BLOCK_SIZE)-1:0] rd_line,
  input  logic                                         fill_en,
  input  logic [INDEX_BITS-1:0]                        fill_index,
  input  logic [TAG_WIDTH-1:0]                         fill_tag,
  input  logic [line_width(DATA_WIDTH, BLOCK_SIZE)-1:0] fill_line,
  input  logic                                         upd_en,
  input  logic [INDEX_BITS-1:0]                        upd_index,
  input  logic [BLOCK_SIZE-1:0]                        upd_offset,
  input  logic [DATA_WIDTH-1:0]                        upd_word
);

  localparam int unsigned LINES      = 1 << INDEX_BITS;
  localparam int unsigned WORDS      = 1 << BLOCK_SIZE;
  localparam int unsigned LINE_WIDTH = line_width(DATA_WIDTH, BLOCK_SIZE);

  logic [LINES-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags [LINES];
  logic [LINE_WIDTH-1:0] data [LINES];
  logic [LINE_WIDTH-1:0] upd_line;

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = data[rd_index];

  // Word update is a read-modify-write of the whole line at upd_index.
  for (genvar g = 0; g < WORDS; g++) begin : g_upd
    assign upd_line[g*DATA_WIDTH +: DATA_WIDTH] =
      (upd_offset == BLOCK_SIZE'(g)) ? upd_word : data[upd_index][g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (inval) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index] <= fill_tag;
      data[fill_index] <= fill_line;
    end else if (upd_en) begin
      data[upd_index] <= upd_line;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate data cache controller with
// a fixed-latency block memory interface and saturating load hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned MEMORY_SIZE   = DEF_MEMORY_SIZE,
  parameter int unsigned BLOCK_SIZE    = DEF_BLOCK_SIZE,
  parameter int unsigned INDEX_BITS    = DEF_INDEX_BITS,
  parameter int unsigned MEM_LATENCY   = DEF_MEM_LATENCY
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         req_valid,
  input  logic                                         req_write,
  input  logic [ADDRESS_WIDTH-1:0]                     req_addr,
  input  logic [DATA_WIDTH-1:0]                        req_wdata,
  output logic                                         req_ready,
  output logic                                         resp_valid,
  output logic [DATA_WIDTH-1:0]                        resp_rdata,
  input  logic                                         flush,
  output logic [ADDRESS_WIDTH-1:0]                     mem_addr,
  output logic [DATA_WIDTH-1:0]                        mem_wdata,
  output logic                                         mem_we,
  input  logic [line_width(DATA_WIDTH, BLOCK_SIZE)-1:0] mem_rdata,
  output logic [15:0]                                  hit_count,
  output logic [15:0]                                  miss_count
);

  localparam int unsigned WORDS      = 1 << BLOCK_SIZE;
  localparam int unsigned TAG_WIDTH  = tag_width(MEMORY_SIZE, BLOCK_SIZE, INDEX_BITS);
  localparam int unsigned LINE_WIDTH = line_width(DATA_WIDTH, BLOCK_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAT_INIT = CNT_WIDTH'(MEM_LATENCY - 1);

  state_e                   state;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     write_q;

  logic [BLOCK_SIZE-1:0]    offset_q;
  logic [INDEX_BITS-1:0]    index_q;
  logic [TAG_WIDTH-1:0]     tag_q;

  logic                     rd_valid;
  logic [TAG_WIDTH-1:0]     rd_tag;
  logic [LINE_WIDTH-1:0]    rd_line;
  logic                     hit;
  logic                     last_beat;
  logic                     fill_en;
  logic                     upd_en;
  logic                     inval;

  logic [DATA_WIDTH-1:0]    line_words [WORDS];
  logic [DATA_WIDTH-1:0]    fill_words [WORDS];

  assign offset_q  = addr_q[BLOCK_SIZE-1:0];
  assign index_q   = addr_q[BLOCK_SIZE+INDEX_BITS-1:BLOCK_SIZE];
  assign tag_q     = addr_q[MEMORY_SIZE-1:BLOCK_SIZE+INDEX_BITS];

  assign hit       = rd_valid && (rd_tag == tag_q);
  assign last_beat = (cnt == '0);
  assign fill_en   = (state == FILL) && last_beat;
  assign upd_en    = (state == LOOKUP) && write_q && hit;
  assign inval     = (state == IDLE) && flush;

  assign req_ready = (state == IDLE) && !flush && !rst;
  assign mem_we    = (state == WRITE) && last_beat;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  for (genvar g = 0; g < WORDS; g++) begin : g_words
    assign line_words[g] = rd_line[g*DATA_WIDTH +: DATA_WIDTH];
    assign fill_words[g] = mem_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  cache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .INDEX_BITS (INDEX_BITS),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .inval      (inval),
    .rd_index   (index_q),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .fill_en    (fill_en),
    .fill_index (index_q),
    .fill_tag   (tag_q),
    .fill_line  (mem_rdata),
    .upd_en     (upd_en),
    .upd_index  (index_q),
    .upd_offset (offset_q),
    .upd_word   (wdata_q)
  );

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    unique case (state)
      LOOKUP: if (!write_q && hit) begin
        resp_valid = 1'b1;
        resp_rdata = line_words[offset_q];
      end
      FILL: if (last_beat) begin
        resp_valid = 1'b1;
        resp_rdata = fill_words[offset_q];
      end
      WRITE: if (last_beat) resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_ready && req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          write_q <= req_write;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          if (write_q) begin
            cnt   <= LAT_INIT;
            state <= WRITE;
          end else if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 16'd1;
            state <= IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 16'd1;
            cnt   <= LAT_INIT;
            state <= FILL;
          end
        end
        FILL, WRITE: begin
          if (last_beat) state <= IDLE;
          else           cnt   <= cnt - CNT_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
